pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline stall/flush controller for the dual-issue core. Collects the load-use request from the forwarding unit, fetch and data-memory stall requests, and the precise exception request from the mem stage. Drives per-register stall/flush for pc, if_id, id1_id2, id2_ex, ex_mem and mem_wb, and issues a registered redirect to fetch. Sequential behaviour covers deferring an exception behind an outstanding memory access, the post-exception redirect cycle, and a stall-cycle performance counter.

## Interface
- CNT_W, 32, stall counter width
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- forward_stall_req  in  1  load-use hazard on id2 operands
- forward_flush_req  in  1  companion bubble request; same cycle as forward_stall_req
- fetch_stall_req  in  1  fetch has no valid instruction this cycle
- mem_stall_req  in  1  data access outstanding in mem stage
- exception_req  in  1  mem-stage instruction raises exception (level, valid while in mem)
- exception_pc  in  32  handler target
- pc_stall, if_id_stall, id1_id2_stall, id2_ex_stall, ex_mem_stall  out  1 each  hold register
- if_id_flush, id1_id2_flush, id2_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target
- ctrl_state  out  2  current FSM state (debug)
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1

## Operation
- States: RUN, EXC_WAIT, REDIRECT. Reset -> RUN.
- RUN priority: mem_stall_req > exception_req > load-use (forward_stall_req | forward_flush_req) > fetch_stall_req.
  - mem_stall_req: pc..ex_mem stall=1, mem_wb_flush=1. If exception_req also set: latch exception_pc, -> EXC_WAIT.
  - exception_req: pc_stall=1; if_id, id1_id2, id2_ex, ex_mem, mem_wb flush=1; latch exception_pc; -> REDIRECT.
  - load-use: pc, if_id, id1_id2 stall=1; id2_ex_flush=1.
  - fetch_stall_req: if_id_flush=1 only.
  - none: all outputs 0.
- EXC_WAIT: mem_stall_req=1 -> mem-stall outputs, stay. mem_stall_req=0 -> exception flush outputs, -> REDIRECT. exception_req and exception_pc ignored (first latch wins).
- REDIRECT: exactly one cycle. redirect_valid=1, redirect_pc=latched target, if_id_flush=1; all other stall/flush 0; all requests ignored; -> RUN.
- Flush and stall never asserted together on the same register.
- stall_cycles: +1 each cycle pc_stall=1; saturates at all-ones.

## Timing
- Stall/flush outputs combinational from state and requests; same-cycle response.
- redirect_valid/redirect_pc are the registered view of state==REDIRECT: redirect_valid rises the cycle after exception flush.
- Exception latency: accept cycle N (flush) -> redirect N+1 -> RUN N+2. Deferred: flush in first cycle mem_stall_req=0, redirect next.
- Reset (any time, including mid EXC_WAIT): state RUN, latched pc 0, redirect_valid 0, redirect_pc 0, stall_cycles 0, ctrl_state 0; combinational outputs 0 with inputs 0.
- Counter wrap: never; holds at 2^CNT_W-1.

## Structure
- pipe_ctrl_def.v: state encodings (PIPE_RUN=2'd0, PIPE_EXC_WAIT=2'd1, PIPE_REDIRECT=2'd2).
- Sub-module sat_counter (CNT_W, inc enable, saturating, async reset) for stall_cycles.
- FSM and output decode in pipe_ctrl.

## Test plan
- forward_stall_req=forward_flush_req=1 for 1 cycle in RUN -> pc/if_id/id1_id2 stall=1, id2_ex_flush=1, others 0; stall_cycles 0->1.
- exception_req=1, exception_pc=0xBFC00380 in RUN -> all five flushes + pc_stall that cycle; next cycle redirect_valid=1, redirect_pc=0xBFC00380, if_id_flush=1; then RUN, redirect_valid=0.
- mem_stall_req=1 for 3 cycles with exception_req (pc 0x80000180) in first -> 3 cycles mem-stall outputs, ctrl_state=1; cycle 4 flush; cycle 5 redirect to 0x80000180.
- mem_stall_req, forward_stall_req, fetch_stall_req all 1 -> only mem-stall pattern (mem_wb_flush=1, id2_ex_flush=0, if_id_flush=0).
- rst pulsed mid EXC_WAIT -> ctrl_state=0, redirect_valid never asserts, stall_cycles=0.
- CNT_W=4, pc_stall held 20 cycles -> stall_cycles reaches 15 and holds.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types: FSM state encodings and stall/flush bundles.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PIPE_RUN      = 2'd0,
        PIPE_EXC_WAIT = 2'd1,
        PIPE_REDIRECT = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id1_id2;
        logic id2_ex;
        logic ex_mem;
    } stall_t;

    typedef struct packed {
        logic if_id;
        logic id1_id2;
        logic id2_ex;
        logic ex_mem;
        logic mem_wb;
    } flush_t;

    localparam stall_t ST_NONE = 5'b00000;
    localparam stall_t ST_MEM  = 5'b11111;
    localparam stall_t ST_EXC  = 5'b10000;
    localparam stall_t ST_LU   = 5'b11100;

    localparam flush_t FL_NONE = 5'b00000;
    localparam flush_t FL_MEM  = 5'b00001;
    localparam flush_t FL_EXC  = 5'b11111;
    localparam flush_t FL_LU   = 5'b00100;
    localparam flush_t FL_IF   = 5'b10000;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with deferred exception redirect.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_stall_req,
    input  logic             forward_flush_req,
    input  logic             fetch_stall_req,
    input  logic             mem_stall_req,
    input  logic             exception_req,
    input  logic [31:0]      exception_pc,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id1_id2_stall,
    output logic             id2_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id1_id2_flush,
    output logic             id2_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);

    import pipe_ctrl_pkg::*;

    pipe_state_e state, state_n;
    logic [31:0] exc_pc_q, exc_pc_n;
    stall_t      st;
    flush_t      fl;

    always_comb begin
        st       = ST_NONE;
        fl       = FL_NONE;
        state_n  = state;
        exc_pc_n = exc_pc_q;
        case (state)
            PIPE_RUN: begin
                if (mem_stall_req) begin
                    st = ST_MEM;
                    fl = FL_MEM;
                    if (exception_req) begin
                        exc_pc_n = exception_pc;
                        state_n  = PIPE_EXC_WAIT;
                    end
                end else if (exception_req) begin
                    st       = ST_EXC;
                    fl       = FL_EXC;
                    exc_pc_n = exception_pc;
                    state_n  = PIPE_REDIRECT;
                end else if (forward_stall_req || forward_flush_req) begin
                    st = ST_LU;
                    fl = FL_LU;
                end else if (fetch_stall_req) begin
                    fl = FL_IF;
                end
            end
            // first latched target wins; later exceptions are ignored here
            PIPE_EXC_WAIT: begin
                if (mem_stall_req) begin
                    st = ST_MEM;
                    fl = FL_MEM;
                end else begin
                    st      = ST_EXC;
                    fl      = FL_EXC;
                    state_n = PIPE_REDIRECT;
                end
            end
            PIPE_REDIRECT: begin
                fl      = FL_IF;
                state_n = PIPE_RUN;
            end
            default: state_n = PIPE_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= PIPE_RUN;
            exc_pc_q       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_n;
            exc_pc_q       <= exc_pc_n;
            redirect_valid <= (state_n == PIPE_REDIRECT);
            if (state_n == PIPE_REDIRECT)
                redirect_pc <= exc_pc_n;
        end
    end

    assign {pc_stall, if_id_stall, id1_id2_stall,
            id2_ex_stall, ex_mem_stall} = st;
    assign {if_id_flush, id1_id2_flush, id2_ex_flush,
            ex_mem_flush, mem_wb_flush} = fl;
    assign ctrl_state = state;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl (CNT_W=4 to reach saturation).
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        fwd_s, fwd_f, fet_s, mem_s, exc;
    logic [31:0] exc_pc;
    logic        pc_st, ifid_st, id12_st, id2ex_st, exmem_st;
    logic        ifid_fl, id12_fl, id2ex_fl, exmem_fl, memwb_fl;
    logic        rv;
    logic [31:0] rpc;
    logic [1:0]  cst;
    logic [3:0]  cnt;
    logic [9:0]  ctl;

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [9:0] P_NONE = 10'b00000_00000;
    localparam logic [9:0] P_LU   = 10'b11100_00100;
    localparam logic [9:0] P_EXC  = 10'b10000_11111;
    localparam logic [9:0] P_MEM  = 10'b11111_00001;
    localparam logic [9:0] P_IF   = 10'b00000_10000;

    pipe_ctrl #(.CNT_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .forward_stall_req (fwd_s),
        .forward_flush_req (fwd_f),
        .fetch_stall_req   (fet_s),
        .mem_stall_req     (mem_s),
        .exception_req     (exc),
        .exception_pc      (exc_pc),
        .pc_stall          (pc_st),
        .if_id_stall       (ifid_st),
        .id1_id2_stall     (id12_st),
        .id2_ex_stall      (id2ex_st),
        .ex_mem_stall      (exmem_st),
        .if_id_flush       (ifid_fl),
        .id1_id2_flush     (id12_fl),
        .id2_ex_flush      (id2ex_fl),
        .ex_mem_flush      (exmem_fl),
        .mem_wb_flush      (memwb_fl),
        .redirect_valid    (rv),
        .redirect_pc       (rpc),
        .ctrl_state        (cst),
        .stall_cycles      (cnt)
    );

    assign ctl = {pc_st, ifid_st, id12_st, id2ex_st, exmem_st,
                  ifid_fl, id12_fl, id2ex_fl, exmem_fl, memwb_fl};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // drive one cycle of requests at the falling edge, settle, then check
    task automatic cyc(input logic ms, input logic ex, input logic lu,
                       input logic fe, input logic [31:0] pc);
        @(negedge clk);
        mem_s  = ms;
        exc    = ex;
        fwd_s  = lu;
        fwd_f  = lu;
        fet_s  = fe;
        exc_pc = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fwd_s = 0; fwd_f = 0; fet_s = 0; mem_s = 0; exc = 0;
        exc_pc = '0;
        @(negedge clk);
        #1;
        chk("rst_ctl", ctl, P_NONE);
        chk("rst_state", cst, 2'd0);
        chk("rst_rv", rv, 1'b0);
        chk("rst_rpc", rpc, 32'h0);
        chk("rst_cnt", cnt, 4'd0);
        rst = 1'b0;

        cyc(0, 0, 1, 0, 32'h0);
        chk("lu_ctl", ctl, P_LU);
        chk("lu_cnt0", cnt, 4'd0);
        cyc(0, 0, 0, 1, 32'h0);
        chk("fet_ctl", ctl, P_IF);
        chk("lu_cnt1", cnt, 4'd1);

        cyc(0, 1, 0, 0, 32'hBFC00380);
        chk("exc_ctl", ctl, P_EXC);
        chk("exc_state", cst, 2'd0);
        chk("exc_rv0", rv, 1'b0);
        cyc(1, 1, 1, 1, 32'h11111111);
        chk("red_ctl", ctl, P_IF);
        chk("red_state", cst, 2'd2);
        chk("red_rv", rv, 1'b1);
        chk("red_rpc", rpc, 32'hBFC00380);
        chk("red_cnt", cnt, 4'd2);
        cyc(0, 0, 0, 0, 32'h0);
        chk("post_ctl", ctl, P_NONE);
        chk("post_state", cst, 2'd0);
        chk("post_rv", rv, 1'b0);

        cyc(1, 1, 0, 0, 32'h80000180);
        chk("mw1_ctl", ctl, P_MEM);
        chk("mw1_state", cst, 2'd0);
        cyc(1, 1, 0, 0, 32'h12345678);
        chk("mw2_ctl", ctl, P_MEM);
        chk("mw2_state", cst, 2'd1);
        chk("mw2_rv", rv, 1'b0);
        cyc(1, 0, 0, 0, 32'h0);
        chk("mw3_ctl", ctl, P_MEM);
        chk("mw3_state", cst, 2'd1);
        cyc(0, 0, 0, 0, 32'h0);
        chk("mw4_ctl", ctl, P_EXC);
        chk("mw4_state", cst, 2'd1);
        cyc(0, 0, 0, 0, 32'h0);
        chk("mw5_state", cst, 2'd2);
        chk("mw5_rv", rv, 1'b1);
        chk("mw5_rpc", rpc, 32'h80000180);
        chk("mw5_ctl", ctl, P_IF);
        chk("mw5_cnt", cnt, 4'd6);
        cyc(0, 0, 0, 0, 32'h0);
        chk("mw6_state", cst, 2'd0);
        chk("mw6_rv", rv, 1'b0);

        cyc(1, 0, 1, 1, 32'h0);
        chk("pri_mem", ctl, P_MEM);
        cyc(0, 1, 1, 1, 32'h00001000);
        chk("pri_exc", ctl, P_EXC);
        chk("pri_cnt", cnt, 4'd7);
        cyc(0, 0, 0, 0, 32'h0);
        chk("pri_state", cst, 2'd2);
        chk("pri_rpc", rpc, 32'h00001000);
        chk("pri_cnt2", cnt, 4'd8);
        cyc(0, 0, 1, 1, 32'h0);
        chk("pri_lu", ctl, P_LU);
        chk("pri_run", cst, 2'd0);

        cyc(1, 1, 0, 0, 32'hDEADBEEF);
        chk("rm1_ctl", ctl, P_MEM);
        cyc(1, 0, 0, 0, 32'h0);
        chk("rm2_state", cst, 2'd1);
        chk("rm2_cnt", cnt, 4'd10);
        #2 rst = 1'b1;
        #1;
        chk("rm_state", cst, 2'd0);
        chk("rm_cnt", cnt, 4'd0);
        chk("rm_rv", rv, 1'b0);
        chk("rm_rpc", rpc, 32'h0);
        mem_s = 1'b0;
        #1;
        chk("rm_ctl", ctl, P_NONE);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 32'h0);
            chk("rm_norv", rv, 1'b0);
            chk("rm_run", cst, 2'd0);
        end

        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, 0, 32'h0);
            chk("sat_step", cnt, (i > 15) ? 64'd15 : 64'(i));
        end
        cyc(0, 0, 0, 0, 32'h0);
        chk("sat_hold", cnt, 4'd15);
        cyc(0, 0, 0, 0, 32'h0);
        chk("sat_idle", cnt, 4'd15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
